freq_meter_mc: RTL
==================

Name: freq_meter_mc

Overview:
- Multi-channel gated frequency meter, parametrised successor to the single free-running saturating counter.
- Counts rising edges of NCH asynchronous input signals over a programmable gate window timed by clk.
- Latches per-channel results with a one-cycle valid strobe and runs back-to-back windows with no dead cycles.
- Sits between external test-signal pins and the readout/display logic of the frequency meter.

Parameters:
- NCH, 2, number of input channels (≥1)
- CNT_W, 32, width of each channel's edge count
- GATE_W, 27, width of the gate-length input and gate timer
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)

Ports:
- clk  in  1  sole clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = measure; 0 = abort/hold idle
- gate_len  in  GATE_W  window length in clk cycles, sampled at window start
- sig_in  in  NCH  asynchronous measured signals
- count_out  out  NCH*CNT_W  latched counts; channel k at bits [k*CNT_W +: CNT_W]
- ovf  out  NCH  per-channel saturation flag for the latched window
- valid  out  1  one-cycle pulse when count_out/ovf update
- busy  out  1  1 while a window is in progress

Behaviour:
- Reset (async, rst=1): sync chains, edge-detect regs, accumulators, gate timer, latched gate length, count_out, ovf, valid, busy all 0. Takes effect immediately, mid-window included; no valid is produced for the interrupted window.
- Per channel: SYNC_STAGES-flop synchroniser, then a prev register. edge = sync & ~prev. Synchroniser and prev run every cycle regardless of enable. A level already high at reset release yields one edge once it emerges from the synchroniser.
- Latency: a sig_in rise is visible as edge SYNC_STAGES+1 clk edges later (worst case, setup-dependent).
- States: IDLE, RUN.
  - IDLE: busy=0, accumulators 0. On enable=1, go to RUN next edge: latch gl = max(gate_len,1), timer=0, busy=1.
  - RUN: each cycle, every channel with edge=1 increments its accumulator; increments saturate at 2^CNT_W-1 and set that channel's sticky sat bit.
  - RUN, window end (timer==gl-1): on that edge, count_out[k] <= acc[k] + edge[k] (saturating) and ovf[k] <= sat[k] | new saturation. An edge in the final cycle counts. valid=1 for exactly the following cycle; accumulators and sat clear; timer=0. If enable=1, re-latch gl from gate_len and stay in RUN (back-to-back, no lost cycle); else go to IDLE.
  - RUN, other cycles: timer increments.
- enable=0 mid-window: next edge go to IDLE, accumulators/timer clear, no valid; count_out/ovf keep the last completed result.
- gate_len changes mid-window are ignored until the next window start. gate_len=0 behaves as 1: every cycle is a window end and valid stays high continuously.
- Edges in the cycle the window opens (IDLE→RUN) are not counted. Window k+1's first cycle is the cycle after window k's end.
- Frequency = count × f_clk / gl; that division is done downstream.
- Max countable rate f_clk/2 per channel (edge needs a low then a high sample).

Test Plan:
- Reset/defaults: rst=1 asserted mid-RUN, no clk edge → count_out=0, ovf=0, valid=0, busy=0 immediately; no valid after release.
- Basic count: NCH=2, gate_len=1000, ch0 toggling every 5 clk (period 10), ch1 held 0, enable=1 → each valid gives ch0=100±1, ch1=0, valid period exactly 1000 clk, busy=1 throughout.
- Window boundary: gate_len=10, single ch0 edge timed to reach edge detect in timer==9 → counted in that window's result (1); same edge at timer==0 of the next window → counted in the next result, not the first.
- Saturation: CNT_W=4, gate_len=100, ch0 period 2 clk (50 edges) → count_out ch0=15, ovf[0]=1; next window with ch0 idle → 0, ovf[0]=0.
- Abort/hold: enable dropped at timer==500 of a 1000 window → no valid, busy=0 next cycle, count_out holds the previous result; re-enable → first valid 1001 cycles later (1 IDLE→RUN cycle + 1000).
- gate_len edge cases: gate_len=0 → valid high every cycle, counts 0 or 1; gate_len changed 1000→200 mid-window → current window ends at 1000, the following one at 200.

Source files
------------

// File: rtl/freq_meter_mc.sv
// ---------------------------------------------------------------------------
// freq_meter_mc
//
// Multi-channel gated frequency meter. Each of NCH asynchronous inputs is
// synchronised and its rising edges are counted over a gate window of
// gate_len clk cycles. At the end of every window the per-channel counts are
// latched into count_out together with a per-channel saturation flag. A
// one-cycle valid strobe marks each update. Windows run back to back while
// enable stays high.
//
// Parameters:
//   NCH         number of input channels (>= 1)
//   CNT_W       width of each channel's edge count
//   GATE_W      width of the gate length and the gate timer
//   SYNC_STAGES synchroniser flops per channel (>= 2)
//
// Ports:
//   clk        sole clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   enable     1 = measure, 0 = abort / stay idle
//   gate_len   window length in clk cycles, sampled at each window start
//   sig_in     asynchronous measured signals, one bit per channel
//   count_out  latched counts, channel k at [k*CNT_W +: CNT_W]
//   ovf        per-channel saturation flag of the latched window
//   valid      one-cycle pulse when count_out/ovf update
//   busy       high while a window is in progress
// ---------------------------------------------------------------------------
module freq_meter_mc #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [GATE_W-1:0]    gate_len,
  input  logic [NCH-1:0]       sig_in,
  output logic [NCH*CNT_W-1:0] count_out,
  output logic [NCH-1:0]       ovf,
  output logic                 valid,
  output logic                 busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [NCH-1:0]         r_prev;
  logic [NCH-1:0]         w_syncOut;
  logic [NCH-1:0]         w_edge;

  logic [CNT_W-1:0]       r_acc [NCH];
  logic [NCH-1:0]         r_sat;
  logic [CNT_W-1:0]       w_accNext [NCH];
  logic [NCH-1:0]         w_satNew;

  logic [GATE_W-1:0]      r_timer;
  logic [GATE_W-1:0]      r_gl;
  logic [GATE_W-1:0]      w_glStart;
  logic                   w_windowEnd;

  logic [NCH*CNT_W-1:0]   r_countOut;
  logic [NCH-1:0]         r_ovf;
  logic                   r_valid;

  // Synchroniser chain plus previous-value register per channel. These run
  // regardless of enable so the edge detector is already primed when a
  // window opens. A level that is high at reset release shows up as one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_sync[k] <= '0;
      end
      r_prev <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], sig_in[k]};
      end
      r_prev <= w_syncOut;
    end
  end

  // Rising-edge detect on the synchronised level.
  always_comb begin
    w_syncOut = '0;
    for (int k = 0; k < NCH; k++) begin
      w_syncOut[k] = r_sync[k][SYNC_STAGES-1];
    end
    w_edge = w_syncOut & ~r_prev;
  end

  // Saturating increment of each accumulator. The increment that would wrap
  // past the all-ones value is dropped and flagged instead, so the latched
  // result sticks at the maximum.
  always_comb begin
    w_satNew = '0;
    for (int k = 0; k < NCH; k++) begin
      w_accNext[k] = r_acc[k];
      if (w_edge[k]) begin
        if (r_acc[k] == CNT_MAX) begin
          w_satNew[k] = 1'b1;
        end else begin
          w_accNext[k] = r_acc[k] + CNT_W'(1);
        end
      end
    end
  end

  // A zero gate length behaves as a one-cycle window.
  assign w_glStart   = (gate_len == '0) ? GATE_ONE : gate_len;
  assign w_windowEnd = (r_state == RUN) && (r_timer == (r_gl - GATE_ONE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A window end always completes and publishes its result
  // even if enable drops in that same cycle; enable only decides whether a
  // new window follows. Dropping enable earlier aborts the window silently.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Gate timer, accumulators and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer    <= '0;
      r_gl       <= '0;
      r_sat      <= '0;
      r_countOut <= '0;
      r_ovf      <= '0;
      r_valid    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      r_valid <= w_windowEnd;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          r_sat   <= '0;
          for (int k = 0; k < NCH; k++) begin
            r_acc[k] <= '0;
          end
          if (enable) begin
            r_gl <= w_glStart;
          end
        end
        RUN: begin
          if (w_windowEnd) begin
            // The edge of the final cycle is folded straight into the result.
            for (int k = 0; k < NCH; k++) begin
              r_countOut[k*CNT_W +: CNT_W] <= w_accNext[k];
              r_acc[k]                     <= '0;
            end
            r_ovf   <= r_sat | w_satNew;
            r_sat   <= '0;
            r_timer <= '0;
            if (enable) begin
              r_gl <= w_glStart;
            end
          end else if (!enable) begin
            r_timer <= '0;
            r_sat   <= '0;
            for (int k = 0; k < NCH; k++) begin
              r_acc[k] <= '0;
            end
          end else begin
            r_timer <= r_timer + GATE_ONE;
            r_sat   <= r_sat | w_satNew;
            for (int k = 0; k < NCH; k++) begin
              r_acc[k] <= w_accNext[k];
            end
          end
        end
        default: begin
          r_timer <= '0;
        end
      endcase
    end
  end

  assign count_out = r_countOut;
  assign ovf       = r_ovf;
  assign valid     = r_valid;
  assign busy      = (r_state == RUN);

endmodule
